serial_loader: RTL and testbench

Boot-time program loader that writes MICRO-1 main memory from the host serial link while the CPU is held in reset. It reads framed bytes from the `uart_receiver` byte interface, assembles 16-bit machine words, and writes them into `main_memory` port A. It answers each load frame with an ACK/NAK byte through the `uart_transmitter` byte interface. On a GO command it releases the CPU and permanently hands the UART and memory port back to `micro_alpha`; the top level muxes those ports on `cpu_rst`.

---
 rtl/serial_loader.sv | 166 ++++++++++++++++
 tb/tb_serial_loader.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_loader.sv
// Boot loader: parses LOAD/GO frames from the UART byte stream, writes 16-bit words
// into main memory, answers each LOAD with ACK/NAK, and releases the CPU on GO.
module serial_loader #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            rx_dout,
    input  logic                  rx_empty,
    output logic                  rx_re,
    output logic [7:0]            tx_din,
    input  logic                  tx_full,
    output logic                  tx_we,
    output logic [ADDR_WIDTH-1:0] mm_addr,
    output logic [DATA_WIDTH-1:0] mm_dout,
    output logic                  mm_we,
    output logic                  cpu_rst
);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR_H, S_ADDR_L, S_CNT_H, S_CNT_L,
        S_DATA_H, S_DATA_L, S_WRITE, S_CSUM, S_ACK, S_RUN
    } state_t;

    localparam logic [7:0] CMD_LOAD = 8'h4C;
    localparam logic [7:0] CMD_GO   = 8'h47;
    localparam logic [7:0] ACK_BYTE = 8'h06;
    localparam logic [7:0] NAK_BYTE = 8'h15;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [15:0]           cnt_q, cnt_d;
    logic [7:0]            sum_q, sum_d;
    logic [7:0]            hi_q, hi_d;
    logic [7:0]            tx_din_q, tx_din_d;
    logic                  tx_we_q, tx_we_d;
    logic                  cpu_rst_q, cpu_rst_d;
    logic                  byte_state;

    always_comb begin
        byte_state = 1'b0;
        case (state_q)
            S_IDLE, S_ADDR_H, S_ADDR_L, S_CNT_H, S_CNT_L,
            S_DATA_H, S_DATA_L, S_CSUM: byte_state = 1'b1;
            default:                    byte_state = 1'b0;
        endcase
    end

    // Combinational pop: a byte state with data available consumes it this edge.
    assign rx_re   = byte_state & ~rx_empty;
    assign mm_we   = (state_q == S_WRITE);
    assign mm_addr = addr_q;
    assign mm_dout = data_q;
    assign tx_din  = tx_din_q;
    assign tx_we   = tx_we_q;
    assign cpu_rst = cpu_rst_q;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        data_d    = data_q;
        cnt_d     = cnt_q;
        sum_d     = sum_q;
        hi_d      = hi_q;
        tx_din_d  = tx_din_q;
        tx_we_d   = 1'b0;
        cpu_rst_d = cpu_rst_q;
        case (state_q)
            S_IDLE: begin
                if (rx_re) begin
                    if (rx_dout == CMD_LOAD) begin
                        state_d = S_ADDR_H;
                    end else if (rx_dout == CMD_GO) begin
                        state_d   = S_RUN;
                        cpu_rst_d = 1'b0;
                    end
                end
            end
            S_ADDR_H: begin
                if (rx_re) begin
                    addr_d  = ADDR_WIDTH'(rx_dout);
                    state_d = S_ADDR_L;
                end
            end
            S_ADDR_L: begin
                if (rx_re) begin
                    addr_d  = ADDR_WIDTH'({addr_q[7:0], rx_dout});
                    state_d = S_CNT_H;
                end
            end
            S_CNT_H: begin
                if (rx_re) begin
                    cnt_d   = {8'h00, rx_dout};
                    state_d = S_CNT_L;
                end
            end
            S_CNT_L: begin
                if (rx_re) begin
                    cnt_d   = {cnt_q[7:0], rx_dout};
                    sum_d   = 8'h00;
                    state_d = (cnt_d != 16'd0) ? S_DATA_H : S_CSUM;
                end
            end
            S_DATA_H: begin
                if (rx_re) begin
                    hi_d    = rx_dout;
                    sum_d   = sum_q + rx_dout;
                    state_d = S_DATA_L;
                end
            end
            S_DATA_L: begin
                if (rx_re) begin
                    data_d  = DATA_WIDTH'({hi_q, rx_dout});
                    sum_d   = sum_q + rx_dout;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                addr_d  = addr_q + ADDR_WIDTH'(1);
                cnt_d   = cnt_q - 16'd1;
                state_d = (cnt_q == 16'd1) ? S_CSUM : S_DATA_H;
            end
            S_CSUM: begin
                if (rx_re) begin
                    tx_din_d = (rx_dout == sum_q) ? ACK_BYTE : NAK_BYTE;
                    state_d  = S_ACK;
                end
            end
            S_ACK: begin
                if (!tx_full) begin
                    tx_we_d = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_RUN:   state_d = S_RUN;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            data_q    <= '0;
            cnt_q     <= '0;
            sum_q     <= '0;
            hi_q      <= '0;
            tx_din_q  <= '0;
            tx_we_q   <= 1'b0;
            cpu_rst_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            cnt_q     <= cnt_d;
            sum_q     <= sum_d;
            hi_q      <= hi_d;
            tx_din_q  <= tx_din_d;
            tx_we_q   <= tx_we_d;
            cpu_rst_q <= cpu_rst_d;
        end
    end

endmodule

// File: tb/tb_serial_loader.sv
// Self-checking bench for serial_loader: directed frames from the test plan plus
// randomized frames with byte gaps and transmit back-pressure against a frame-level model.
module tb_serial_loader;

    typedef logic [7:0]  bq_t[$];
    typedef logic [15:0] hq_t[$];
    typedef logic [31:0] wq_t[$];

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_dout;
    logic        rx_empty;
    logic        rx_re;
    logic [7:0]  tx_din;
    logic        tx_full;
    logic        tx_we;
    logic [15:0] mm_addr;
    logic [15:0] mm_dout;
    logic        mm_we;
    logic        cpu_rst;

    bq_t rx_q;
    wq_t wr_log;
    bq_t tx_log;
    int  n_cmp = 0;
    int  n_err = 0;
    int  rx_viol = 0;
    int  tx_viol = 0;
    int  pop_cnt = 0;
    bit  pop_pending = 0;
    bit  gap_en = 0;

    serial_loader #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .rx_dout(rx_dout), .rx_empty(rx_empty), .rx_re(rx_re),
        .tx_din(tx_din), .tx_full(tx_full), .tx_we(tx_we), .mm_addr(mm_addr),
        .mm_dout(mm_dout), .mm_we(mm_we), .cpu_rst(cpu_rst)
    );

    always #5 clk = ~clk;

    // Observe interface activity mid-cycle; pops take effect on the following rising edge.
    always @(negedge clk) begin
        if (rst_n && rx_re) begin
            if (rx_q.size() == 0 || rx_empty) rx_viol++;
            else pop_pending = 1'b1;
        end
        if (mm_we) wr_log.push_back({mm_addr, mm_dout});
        if (tx_we) begin
            tx_log.push_back(tx_din);
            if (tx_full) tx_viol++;
        end
    end

    always @(posedge clk) begin
        if (pop_pending) begin
            rx_q.delete(0);
            pop_cnt++;
            pop_pending = 1'b0;
        end
        #1;
        rx_empty = (rx_q.size() == 0) || (gap_en && ($urandom_range(0, 1) == 1));
        rx_dout  = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
    end

    task automatic apply_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        rx_q.delete();
        rx_empty = 1'b1;
        pop_pending = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic send_frame(input bq_t frame, input bit hold_full, output wq_t obs_w,
                              output bq_t obs_tx, output int held_tx, output bit timeout);
        int t;
        wr_log.delete();
        tx_log.delete();
        held_tx = 0;
        timeout = 1'b0;
        if (hold_full) tx_full = 1'b1;
        foreach (frame[i]) rx_q.push_back(frame[i]);
        t = 0;
        while (rx_q.size() != 0 && t < 4000) begin
            @(negedge clk);
            t++;
        end
        if (rx_q.size() != 0) timeout = 1'b1;
        if (hold_full) begin
            repeat (20) @(negedge clk);
            held_tx = tx_log.size();
            tx_full = 1'b0;
        end
        t = 0;
        while (tx_log.size() == 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (tx_log.size() == 0) timeout = 1'b1;
        repeat (6) @(negedge clk);
        obs_w  = wr_log;
        obs_tx = tx_log;
    endtask

    // Frame-level reference: builds the byte stream and predicts writes and reply.
    task automatic model_frame(input logic [15:0] addr, input hq_t words, input bit bad,
                               output bq_t frame, output wq_t exp_w, output logic [7:0] exp_ack);
        logic [7:0]  s;
        logic [7:0]  cs;
        logic [15:0] cnt;
        s = 8'h00;
        cnt = 16'(words.size());
        frame = '{8'h4C, addr[15:8], addr[7:0], cnt[15:8], cnt[7:0]};
        exp_w.delete();
        foreach (words[i]) begin
            frame.push_back(words[i][15:8]);
            frame.push_back(words[i][7:0]);
            s = s + words[i][15:8] + words[i][7:0];
            exp_w.push_back({addr + 16'(i), words[i]});
        end
        cs = bad ? s + 8'($urandom_range(1, 255)) : s;
        frame.push_back(cs);
        exp_ack = bad ? 8'h15 : 8'h06;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rx_empty = 1'b1;
        rx_dout = 8'h00;
        tx_full = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        n_cmp++;
        if (rx_re !== 1'b0) begin n_err++; $display("FAIL reset_rx_re got=%b want=0", rx_re); end
        n_cmp++;
        if (tx_we !== 1'b0) begin n_err++; $display("FAIL reset_tx_we got=%b want=0", tx_we); end
        n_cmp++;
        if (tx_din !== 8'h00) begin n_err++; $display("FAIL reset_tx_din got=%h want=00", tx_din); end
        n_cmp++;
        if (mm_we !== 1'b0) begin n_err++; $display("FAIL reset_mm_we got=%b want=0", mm_we); end
        n_cmp++;
        if (mm_addr !== 16'h0000) begin n_err++; $display("FAIL reset_mm_addr got=%h want=0000", mm_addr); end
        n_cmp++;
        if (mm_dout !== 16'h0000) begin n_err++; $display("FAIL reset_mm_dout got=%h want=0000", mm_dout); end
        n_cmp++;
        if (cpu_rst !== 1'b1) begin n_err++; $display("FAIL reset_cpu_rst got=%b want=1", cpu_rst); end
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_basic_load();
        bq_t f = '{8'h4C, 8'h00, 8'h10, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hBE};
        wq_t ew = '{32'h0010_1234, 32'h0011_ABCD};
        wq_t ow; bq_t otx; int held; bit to;
        send_frame(f, 1'b0, ow, otx, held, to);
        n_cmp++;
        if (to) begin n_err++; $display("FAIL basic_timeout got=1 want=0"); end
        n_cmp++;
        if (otx.size() != 1 || otx[0] !== 8'h06) begin
            n_err++; $display("FAIL basic_ack count=%0d first=%h want=1x06", otx.size(), otx.size() ? otx[0] : 8'hxx);
        end
        n_cmp++;
        if (ow.size() != ew.size()) begin
            n_err++; $display("FAIL basic_wr_count got=%0d want=%0d", ow.size(), ew.size());
        end else begin
            foreach (ew[i]) begin
                n_cmp++;
                if (ow[i] !== ew[i]) begin n_err++; $display("FAIL basic_wr%0d got=%h want=%h", i, ow[i], ew[i]); end
            end
        end
    endtask

    task automatic test_bad_csum();
        bq_t f = '{8'h4C, 8'h00, 8'h10, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hBF};
        wq_t ew = '{32'h0010_1234, 32'h0011_ABCD};
        wq_t ow; bq_t otx; int held; bit to;
        send_frame(f, 1'b0, ow, otx, held, to);
        n_cmp++;
        if (to) begin n_err++; $display("FAIL nak_timeout got=1 want=0"); end
        n_cmp++;
        if (otx.size() != 1 || otx[0] !== 8'h15) begin
            n_err++; $display("FAIL nak_byte count=%0d first=%h want=1x15", otx.size(), otx.size() ? otx[0] : 8'hxx);
        end
        n_cmp++;
        if (ow.size() != ew.size()) begin
            n_err++; $display("FAIL nak_wr_count got=%0d want=%0d", ow.size(), ew.size());
        end else begin
            foreach (ew[i]) begin
                n_cmp++;
                if (ow[i] !== ew[i]) begin n_err++; $display("FAIL nak_wr%0d got=%h want=%h", i, ow[i], ew[i]); end
            end
        end
        test_basic_load();
    endtask

    task automatic test_wrap_and_empty();
        bq_t f = '{8'h4C, 8'hFF, 8'hFF, 8'h00, 8'h02, 8'h00, 8'h01, 8'h00, 8'h02, 8'h03};
        bq_t f0 = '{8'h4C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        wq_t ew = '{32'hFFFF_0001, 32'h0000_0002};
        wq_t ow; bq_t otx; int held; bit to;
        send_frame(f, 1'b0, ow, otx, held, to);
        n_cmp++;
        if (to || otx.size() != 1 || otx[0] !== 8'h06) begin
            n_err++; $display("FAIL wrap_ack timeout=%0d count=%0d want=1x06", to, otx.size());
        end
        n_cmp++;
        if (ow.size() != ew.size()) begin
            n_err++; $display("FAIL wrap_wr_count got=%0d want=%0d", ow.size(), ew.size());
        end else begin
            foreach (ew[i]) begin
                n_cmp++;
                if (ow[i] !== ew[i]) begin n_err++; $display("FAIL wrap_wr%0d got=%h want=%h", i, ow[i], ew[i]); end
            end
        end
        send_frame(f0, 1'b0, ow, otx, held, to);
        n_cmp++;
        if (to || otx.size() != 1 || otx[0] !== 8'h06) begin
            n_err++; $display("FAIL cnt0_ack timeout=%0d count=%0d want=1x06", to, otx.size());
        end
        n_cmp++;
        if (ow.size() != 0) begin n_err++; $display("FAIL cnt0_wr_count got=%0d want=0", ow.size()); end
    endtask

    task automatic test_random_backpressure();
        gap_en = 1'b1;
        for (int k = 0; k < 8; k++) begin
            hq_t w; bq_t f; wq_t ew; wq_t ow; bq_t otx;
            logic [7:0] ea; logic [15:0] a; int n; int held; bit to; bit bad;
            a = (k == 0) ? 16'hFFFE : 16'($urandom);
            n = (k == 0) ? 4 : $urandom_range(0, 5);
            for (int i = 0; i < n; i++) w.push_back(16'($urandom));
            bad = ($urandom_range(0, 3) == 0);
            model_frame(a, w, bad, f, ew, ea);
            send_frame(f, 1'b1, ow, otx, held, to);
            n_cmp++;
            if (held != 0) begin n_err++; $display("FAIL rnd%0d_tx_while_full got=%0d want=0", k, held); end
            n_cmp++;
            if (to || otx.size() != 1 || otx[0] !== ea) begin
                n_err++; $display("FAIL rnd%0d_ack timeout=%0d count=%0d want=1x%h", k, to, otx.size(), ea);
            end
            n_cmp++;
            if (ow.size() != ew.size()) begin
                n_err++; $display("FAIL rnd%0d_wr_count got=%0d want=%0d", k, ow.size(), ew.size());
            end else begin
                foreach (ew[i]) begin
                    n_cmp++;
                    if (ow[i] !== ew[i]) begin n_err++; $display("FAIL rnd%0d_wr%0d got=%h want=%h", k, i, ow[i], ew[i]); end
                end
            end
        end
        gap_en = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_go();
        int t; int pops;
        wr_log.delete();
        tx_log.delete();
        @(negedge clk);
        n_cmp++;
        if (cpu_rst !== 1'b1) begin n_err++; $display("FAIL go_pre_cpu_rst got=%b want=1", cpu_rst); end
        rx_q.push_back(8'h00); rx_q.push_back(8'h7F); rx_q.push_back(8'h47); rx_q.push_back(8'h4C);
        t = 0;
        while (!(rx_re && rx_dout == 8'h47) && t < 100) begin
            @(negedge clk);
            t++;
        end
        n_cmp++;
        if (t >= 100) begin n_err++; $display("FAIL go_consume_timeout got=%0d want<100", t); end
        n_cmp++;
        if (cpu_rst !== 1'b1) begin n_err++; $display("FAIL go_cpu_rst_before_edge got=%b want=1", cpu_rst); end
        @(posedge clk);
        #1;
        n_cmp++;
        if (cpu_rst !== 1'b0) begin n_err++; $display("FAIL go_cpu_rst_after_edge got=%b want=0", cpu_rst); end
        @(negedge clk);
        pops = pop_cnt;
        repeat (30) @(negedge clk);
        n_cmp++;
        if (rx_q.size() != 1 || rx_q[0] !== 8'h4C || pop_cnt != pops || rx_re !== 1'b0) begin
            n_err++; $display("FAIL go_no_pop left=%0d pops=%0d rx_re=%b want=1,0,0", rx_q.size(), pop_cnt - pops, rx_re);
        end
        n_cmp++;
        if (wr_log.size() != 0 || tx_log.size() != 0 || cpu_rst !== 1'b0) begin
            n_err++; $display("FAIL go_quiet writes=%0d tx=%0d cpu_rst=%b want=0,0,0", wr_log.size(), tx_log.size(), cpu_rst);
        end
    endtask

    task automatic test_mid_reset();
        int t;
        apply_reset();
        rx_q.push_back(8'h4C); rx_q.push_back(8'h00); rx_q.push_back(8'h10); rx_q.push_back(8'h00);
        t = 0;
        while (rx_q.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({rx_re, tx_we, tx_din, mm_we, mm_addr, mm_dout, cpu_rst} !== {1'b0, 1'b0, 8'h00, 1'b0, 16'h0, 16'h0, 1'b1}) begin
            n_err++; $display("FAIL midrst_outputs got=%b/%b/%h/%b/%h/%h/%b want=0/0/00/0/0000/0000/1",
                              rx_re, tx_we, tx_din, mm_we, mm_addr, mm_dout, cpu_rst);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        test_basic_load();
    endtask

    initial begin
        rst_n = 1'b0;
        rx_empty = 1'b1;
        rx_dout = 8'h00;
        tx_full = 1'b0;
        test_reset();
        test_basic_load();
        test_bad_csum();
        test_wrap_and_empty();
        test_random_backpressure();
        test_go();
        test_mid_reset();
        n_cmp++;
        if (rx_viol != 0) begin n_err++; $display("FAIL rx_re_when_empty got=%0d want=0", rx_viol); end
        n_cmp++;
        if (tx_viol != 0) begin n_err++; $display("FAIL tx_we_when_full got=%0d want=0", tx_viol); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=expired want=finish");
        $fatal(1, "bench time limit");
    end

endmodule
